harvard_test_mem: RTL and testbench
===================================

# harvard_test_mem

Parametrised Harvard memory and run controller for bench-level testing of `mips_cpu_harvard`. It replaces hand-driven `instr_readdata`/`data_readdata` with real instruction and data RAMs. The RAMs are preloaded through a valid/ready init port. The block sequences the CPU reset and clock enable, then monitors execution until halt, fault or cycle timeout. It sits between a bench (or host loader) and the CPU's instruction and data buses.

## Interface
- `INSTR_DEPTH`, 256: instruction RAM depth in 32-bit words; power of 2.
- `DATA_DEPTH`, 256: data RAM depth in 32-bit words; power of 2.
- `INSTR_BASE`, 32'hBFC0_0000: byte base address of the instruction window.
- `DATA_BASE`, 32'h0000_0000: byte base address of the data window.
- `RESET_HOLD`, 2: cycles `cpu_reset` is held high after `start`; must be ≥1.
- `MAX_CYCLES`, 10000: RUN-cycle limit before timeout fault.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `init_valid` in 1: init beat valid.
- `init_ready` out 1: init beat accepted when high with `init_valid`.
- `init_target` in 1: 0 selects the instruction RAM, 1 selects the data RAM.
- `init_addr` in 32: byte address; used only on the first beat of a segment.
- `init_data` in 32: word to write.
- `init_last` in 1: last beat of the segment.
- `start` in 1: begin a run; honoured only in LOAD.
- `cpu_reset` out 1: active-high reset to the CPU.
- `cpu_clk_enable` out 1: clock enable to the CPU.
- `cpu_active` in 1: the CPU's `active` output.
- `instr_address` in 32: CPU instruction fetch address.
- `instr_readdata` out 32: fetched instruction.
- `data_address` in 32: CPU data address.
- `data_write` in 1: CPU data write strobe.
- `data_read` in 1: CPU data read strobe.
- `data_writedata` in 32: CPU write data.
- `data_readdata` out 32: CPU read data.
- `done` out 1: sticky; the CPU halted cleanly.
- `fault` out 1: sticky; an error occurred.
- `fault_code` out 2: 0 none, 1 out-of-window access, 2 read and write together, 3 timeout.
- `cycle_count` out 32: RUN cycles elapsed.

## Operation
- FSM states are LOAD, HOLD, RUN, DONE and FAULT. Reset enters LOAD.
- **LOAD**
  - `init_ready`=1, `cpu_reset`=1, `cpu_clk_enable`=0.
  - Each accepted beat writes `init_data` into the RAM selected by `init_target`.
  - The word index on the first beat of a segment is `(init_addr - base) >> 2`. Later beats of the same segment use the previous index + 1, wrapping modulo depth.
  - `init_last` closes the segment; the next beat starts a new segment.
  - A first-beat address outside the target window, or unaligned, drops the beat silently. `init_ready` still acknowledges it.
  - `start`=1 moves to HOLD. If `start` and a beat arrive in the same cycle, the beat is written first.
- **HOLD**
  - `init_ready`=0, `cpu_reset`=1, `cpu_clk_enable`=1.
  - Stays RESET_HOLD cycles, then moves to RUN.
- **RUN**
  - `cpu_reset`=0, `cpu_clk_enable`=1; `cycle_count` increments each cycle.
  - `cpu_active`=0 moves to DONE.
  - Faults move to FAULT with the matching code. Fault checks take priority over the halt check in the same cycle.
    - Code 1: instruction fetch outside the instruction window, or a data access outside the data window, or an unaligned data access.
    - Code 2: `data_read` and `data_write` both high.
    - Code 3: `cycle_count` reaches MAX_CYCLES.
- **DONE / FAULT**
  - `cpu_clk_enable`=0 and `cpu_reset`=0; the CPU state is frozen for inspection.
  - Exit only by `reset`.
- **Memory access**
  - Reads are combinational. An out-of-window read returns 32'h0.
  - Data writes happen on the rising edge when RUN && `data_write` && in-window && aligned. Writes are suppressed on the faulting cycle.
  - A read of the same word as a same-cycle write returns the old value.
- **Arithmetic**
  - Window test is `(addr - BASE) < 4*DEPTH`, computed in 32-bit unsigned arithmetic.
  - `cycle_count` saturates at MAX_CYCLES.

## Timing
- Reset values:
  - Outputs: `init_ready`=1, `cpu_reset`=1, `cpu_clk_enable`=0, `done`=0, `fault`=0, `fault_code`=0, `cycle_count`=0.
  - RAM contents are not reset.
- Init beat acceptance: one beat per cycle, zero bubbles.
- `start` sampled at edge N gives HOLD from N+1 and RUN from N+1+RESET_HOLD.
- Halt seen at edge N sets `done` visible after N; `cpu_clk_enable` falls in the same cycle.
- `reset` asserted in any state returns immediately (asynchronously) to LOAD. RAM contents are kept.

## Structure
- Package `harvard_test_pkg` holds:
  - the `state_t` enum;
  - the `fault_t` enum with codes 0–3;
  - a window-check function `in_window(addr, base, depth)`.
- Sub-module `word_ram` (parameters DEPTH, 32-bit): one synchronous write port, one combinational read port.
- Instantiate `word_ram` twice. Each write port is muxed between the init path and the CPU path by state.

## Test plan
- Load 3 instruction words at 32'hBFC0_0000 (beats 32'h8C02_0000, 32'h0000_0000, 32'h0000_0008), then `start`.
  - `cpu_reset` high exactly 2 cycles, then RUN.
  - `instr_address`=32'hBFC0_0004 reads 32'h0000_0000.
- Data segment at DATA_BASE+8 with 2 beats, 32'h1111_1111 and 32'h2222_2222.
  - In RUN, `data_address`=0xC reads 32'h2222_2222.
  - A write of 32'hDEAD_BEEF to 0x8 reads back next cycle.
- In RUN, drive `data_address`=0x400 with `data_read` (DEPTH 256).
  - `fault`=1, `fault_code`=1, `cpu_clk_enable`=0 next cycle.
  - Check the same fault with `data_write`, and that no write occurs.
- Assert `data_read` and `data_write` together in RUN.
  - `fault_code`=2; DATA RAM unchanged.
- Set MAX_CYCLES=20 and hold `cpu_active`=1.
  - `fault_code`=3 with `cycle_count`=20.
- Drop `cpu_active` at RUN cycle 7.
  - `done`=1, `cycle_count`=7, `cpu_clk_enable`=0.
  - Assert `reset` mid-run: LOAD, all outputs at reset values, RAM preserved.

Source files
------------

// File: rtl/harvard_test_mem_pkg.sv
// harvard_test_pkg: shared types and helpers for the harvard_test_mem run controller.
//   state_t   - controller FSM states
//   fault_t   - fault codes reported on fault_code
//   in_window - 32-bit unsigned window test: (addr - base) < 4*depth
package harvard_test_pkg;

    typedef enum logic [2:0] {
        StLoad,
        StHold,
        StRun,
        StDone,
        StFault
    } state_t;

    typedef enum logic [1:0] {
        FaultNone    = 2'd0,
        FaultWindow  = 2'd1,
        FaultRdWr    = 2'd2,
        FaultTimeout = 2'd3
    } fault_t;

    // Wrapping subtraction makes addresses below base land far above the limit.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input int unsigned depth);
        logic [31:0] limit;
        limit = depth << 2;
        return (addr - base) < limit;
    endfunction

endpackage

// File: rtl/harvard_test_mem_if.sv
// harvard_test_mem_if: init/load port, run control and CPU instruction/data buses.
//   slave  - seen by harvard_test_mem (drives ready, readdata, CPU control, status)
//   master - seen by the bench/host and CPU side
interface harvard_test_mem_if;
    // Init (preload) port
    logic        init_valid;
    logic        init_ready;
    logic        init_target;
    logic [31:0] init_addr;
    logic [31:0] init_data;
    logic        init_last;
    logic        start;
    // CPU control
    logic        cpu_reset;
    logic        cpu_clk_enable;
    logic        cpu_active;
    // CPU buses
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    // Run status
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] cycle_count;

    modport slave (
        input  init_valid, init_target, init_addr, init_data, init_last, start,
        input  cpu_active, instr_address, data_address, data_write, data_read, data_writedata,
        output init_ready, cpu_reset, cpu_clk_enable, instr_readdata, data_readdata,
        output done, fault, fault_code, cycle_count
    );

    modport master (
        output init_valid, init_target, init_addr, init_data, init_last, start,
        output cpu_active, instr_address, data_address, data_write, data_read, data_writedata,
        input  init_ready, cpu_reset, cpu_clk_enable, instr_readdata, data_readdata,
        input  done, fault, fault_code, cycle_count
    );
endinterface

// File: rtl/word_ram.sv
// word_ram: DEPTH x 32-bit RAM, one synchronous write port, one combinational read port.
// Contents are not reset.
//   clk_i   - write clock
//   we_i    - write enable
//   waddr_i - write word index
//   wdata_i - write data
//   raddr_i - read word index
//   rdata_o - read data (old value when reading the word being written)
module word_ram #(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned Aw = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [Aw-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [Aw-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/harvard_test_mem.sv
// harvard_test_mem: instruction/data RAMs plus run controller for a Harvard MIPS CPU.
// Preloads RAMs through the init port, sequences CPU reset/clock enable, then watches
// the run for halt, bus faults and cycle timeout.
//   clk   - clock, all state on the rising edge
//   reset - asynchronous active-low reset (returns to LOAD, RAM kept)
//   bus   - harvard_test_mem_if.slave (init port, CPU buses, status)
module harvard_test_mem
    import harvard_test_pkg::*;
#(
    parameter int unsigned INSTR_DEPTH = 256,
    parameter int unsigned DATA_DEPTH  = 256,
    parameter logic [31:0] INSTR_BASE  = 32'hBFC0_0000,
    parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
    parameter int unsigned RESET_HOLD  = 2,
    parameter int unsigned MAX_CYCLES  = 10000
) (
    input logic               clk,
    input logic               reset,
    harvard_test_mem_if.slave bus
);
    localparam int unsigned Iaw = $clog2(INSTR_DEPTH);
    localparam int unsigned Daw = $clog2(DATA_DEPTH);

    state_t      state_q;
    fault_t      code_q;
    logic        done_q, fault_q;
    logic [31:0] hold_cnt_q, cycle_q;
    logic        seg_first_q, seg_drop_q;
    logic [31:0] seg_idx_q;

    // Init path
    logic [31:0] init_base, init_mask, init_off, init_idx;
    logic        init_first_ok, init_we;

    always_comb begin
        init_base     = bus.init_target ? DATA_BASE : INSTR_BASE;
        init_mask     = bus.init_target ? 32'(DATA_DEPTH - 1) : 32'(INSTR_DEPTH - 1);
        init_off      = bus.init_addr - init_base;
        init_first_ok = (bus.init_target ? in_window(bus.init_addr, DATA_BASE, DATA_DEPTH)
                                         : in_window(bus.init_addr, INSTR_BASE, INSTR_DEPTH))
                        && (bus.init_addr[1:0] == 2'b00);
        init_idx      = seg_first_q ? {2'b00, init_off[31:2]} : ((seg_idx_q + 32'd1) & init_mask);
        // A rejected first beat drops the remainder of its segment too.
        init_we       = (state_q == StLoad) && bus.init_valid
                        && (seg_first_q ? init_first_ok : !seg_drop_q);
    end

    // CPU path and fault detection
    logic [31:0] instr_off, data_off, cycle_next;
    logic        instr_ok, data_in_win, data_aligned, data_acc, run;
    logic        fault_win, fault_rw, fault_to, fault_any, cpu_we;
    fault_t      fault_sel;

    always_comb begin
        run          = (state_q == StRun);
        instr_off    = bus.instr_address - INSTR_BASE;
        data_off     = bus.data_address - DATA_BASE;
        instr_ok     = in_window(bus.instr_address, INSTR_BASE, INSTR_DEPTH);
        data_in_win  = in_window(bus.data_address, DATA_BASE, DATA_DEPTH);
        data_aligned = (bus.data_address[1:0] == 2'b00);
        data_acc     = bus.data_read || bus.data_write;
        cycle_next   = (cycle_q >= 32'(MAX_CYCLES)) ? cycle_q : cycle_q + 32'd1;
        fault_win    = !instr_ok || (data_acc && !(data_in_win && data_aligned));
        fault_rw     = bus.data_read && bus.data_write;
        fault_to     = (cycle_next == 32'(MAX_CYCLES));
        fault_any    = fault_win || fault_rw || fault_to;
        fault_sel    = fault_win ? FaultWindow : (fault_rw ? FaultRdWr : FaultTimeout);
        cpu_we       = run && bus.data_write && data_in_win && data_aligned && !fault_any;
    end

    // RAMs
    logic [31:0] iram_rdata, dram_rdata;

    word_ram #(.DEPTH(INSTR_DEPTH)) u_iram (
        .clk_i   (clk),
        .we_i    (init_we && !bus.init_target),
        .waddr_i (init_idx[Iaw-1:0]),
        .wdata_i (bus.init_data),
        .raddr_i (instr_off[Iaw+1:2]),
        .rdata_o (iram_rdata)
    );

    word_ram #(.DEPTH(DATA_DEPTH)) u_dram (
        .clk_i   (clk),
        .we_i    ((init_we && bus.init_target) || cpu_we),
        .waddr_i (run ? data_off[Daw+1:2] : init_idx[Daw-1:0]),
        .wdata_i (run ? bus.data_writedata : bus.init_data),
        .raddr_i (data_off[Daw+1:2]),
        .rdata_o (dram_rdata)
    );

    assign bus.instr_readdata = instr_ok ? iram_rdata : 32'h0;
    assign bus.data_readdata  = data_in_win ? dram_rdata : 32'h0;

    // Controller
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StLoad;
            code_q      <= FaultNone;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            hold_cnt_q  <= '0;
            cycle_q     <= '0;
            seg_first_q <= 1'b1;
            seg_drop_q  <= 1'b0;
            seg_idx_q   <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (bus.init_valid) begin
                        seg_first_q <= bus.init_last;
                        seg_idx_q   <= init_idx;
                        if (seg_first_q) begin
                            seg_drop_q <= !init_first_ok;
                        end
                    end
                    if (bus.start) begin
                        state_q    <= StHold;
                        hold_cnt_q <= '0;
                    end
                end
                StHold: begin
                    hold_cnt_q <= hold_cnt_q + 32'd1;
                    if (hold_cnt_q == 32'(RESET_HOLD - 1)) begin
                        state_q <= StRun;
                        cycle_q <= '0;
                    end
                end
                StRun: begin
                    cycle_q <= cycle_next;
                    if (fault_any) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                        code_q  <= fault_sel;
                    end else if (!bus.cpu_active) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                default: ;  // StDone, StFault: frozen until reset
            endcase
        end
    end

    assign bus.init_ready     = (state_q == StLoad);
    assign bus.cpu_reset      = (state_q == StLoad) || (state_q == StHold);
    assign bus.cpu_clk_enable = (state_q == StHold) || (state_q == StRun);
    assign bus.done           = done_q;
    assign bus.fault          = fault_q;
    assign bus.fault_code     = code_q;
    assign bus.cycle_count    = cycle_q;
endmodule

// File: tb/tb_harvard_test_mem.sv
// Bench for harvard_test_mem: directed load/run scenarios; expected read data and
// end-of-run status are queued by the stimulus and checked by a separate monitor.
module tb_harvard_test_mem;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    harvard_test_mem_if bus ();

    harvard_test_mem #(.MAX_CYCLES(20)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        done;
        logic        fault;
        logic [1:0]  code;
        logic [31:0] count;
    } end_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rd_q[$];
    logic [31:0] ins_q[$];
    end_t        ev_q[$];
    logic        instr_probe = 1'b0;
    logic        prev_end    = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none", name);
    endfunction

    // Monitor: compares whenever the DUT presents a read or finishes a run.
    always @(negedge clk) begin
        logic [31:0] e;
        end_t        ev;
        if (bus.cpu_clk_enable && !bus.cpu_reset) begin
            if (bus.data_read && !bus.data_write) begin
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    check("data_readdata", bus.data_readdata, e);
                end else flag("unexpected_read");
            end
            if (instr_probe) begin
                if (ins_q.size() > 0) begin
                    e = ins_q.pop_front();
                    check("instr_readdata", bus.instr_readdata, e);
                end else flag("unexpected_fetch");
            end
        end
        if ((bus.done || bus.fault) && !prev_end) begin
            if (ev_q.size() > 0) begin
                ev = ev_q.pop_front();
                check("end_done", 32'(bus.done), 32'(ev.done));
                check("end_fault", 32'(bus.fault), 32'(ev.fault));
                check("end_code", 32'(bus.fault_code), 32'(ev.code));
                check("end_count", bus.cycle_count, ev.count);
                check("end_clk_en", 32'(bus.cpu_clk_enable), 32'd0);
                check("end_cpu_reset", 32'(bus.cpu_reset), 32'd0);
            end else flag("unexpected_end");
        end
        prev_end = bus.done || bus.fault;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_init_ready"}, 32'(bus.init_ready), 32'd1);
        check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
        check({tag, "_clk_en"}, 32'(bus.cpu_clk_enable), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_fault"}, 32'(bus.fault), 32'd0);
        check({tag, "_code"}, 32'(bus.fault_code), 32'd0);
        check({tag, "_count"}, bus.cycle_count, 32'd0);
    endtask

    task automatic beat(input logic tgt, input logic [31:0] addr, input logic [31:0] data,
                        input logic last, input logic st);
        bus.init_valid  = 1'b1;
        bus.init_target = tgt;
        bus.init_addr   = addr;
        bus.init_data   = data;
        bus.init_last   = last;
        bus.start       = st;
        check("beat_ready", 32'(bus.init_ready), 32'd1);
        tick();
        bus.init_valid = 1'b0;
        bus.init_last  = 1'b0;
        bus.start      = 1'b0;
    endtask

    // Called one cycle after start was sampled; leaves the bench in RUN cycle 1.
    task automatic hold_checks();
        check("hold1_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("hold1_clk_en", 32'(bus.cpu_clk_enable), 32'd1);
        check("hold1_init_ready", 32'(bus.init_ready), 32'd0);
        tick();
        check("hold2_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        tick();
        check("run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        check("run_clk_en", 32'(bus.cpu_clk_enable), 32'd1);
        check("run_count", bus.cycle_count, 32'd0);
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        hold_checks();
    endtask

    task automatic push_end(input logic f, input logic [1:0] code, input logic [31:0] cnt);
        end_t ev;
        ev.done  = !f;
        ev.fault = f;
        ev.code  = code;
        ev.count = cnt;
        ev_q.push_back(ev);
    endtask

    task automatic wait_end(input int bound);
        for (int i = 0; i < bound && ev_q.size() > 0; i++) tick();
        if (ev_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL end_wait: got no done/fault expected one within %0d cycles", bound);
            ev_q.delete();
        end
    endtask

    task automatic idle_cpu();
        bus.data_read     = 1'b0;
        bus.data_write    = 1'b0;
        bus.cpu_active    = 1'b1;
        bus.instr_address = 32'hBFC0_0000;
        bus.data_address  = 32'h0;
        instr_probe       = 1'b0;
    endtask

    task automatic do_reset();
        idle_cpu();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.init_valid  = 1'b0;
        bus.init_target = 1'b0;
        bus.init_addr   = 32'h0;
        bus.init_data   = 32'h0;
        bus.init_last   = 1'b0;
        bus.start       = 1'b0;
        bus.data_writedata = 32'h0;
        idle_cpu();
        tick();
        tick();
        check_reset_values("por");
        rst_n = 1'b1;
        tick();

        // Load: 3 instructions, data segments incl. wrap and two dropped segments
        beat(1'b0, 32'hBFC0_0000, 32'h8C02_0000, 1'b0, 1'b0);
        beat(1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
        beat(1'b0, 32'h0, 32'h0000_0008, 1'b1, 1'b0);
        beat(1'b1, 32'h8, 32'h1111_1111, 1'b0, 1'b0);
        beat(1'b1, 32'h0, 32'h2222_2222, 1'b1, 1'b0);
        beat(1'b1, 32'h3FC, 32'h7777_7777, 1'b0, 1'b0);
        beat(1'b1, 32'h0, 32'h0A0A_0A0A, 1'b1, 1'b0);    // wraps to word 0
        beat(1'b1, 32'h400, 32'h9999_9999, 1'b1, 1'b0);  // out of window: dropped
        beat(1'b1, 32'h2, 32'hEEEE_EEEE, 1'b1, 1'b0);    // unaligned: dropped
        beat(1'b1, 32'h10, 32'h3333_3333, 1'b1, 1'b1);   // beat and start together
        hold_checks();

        // Run 1: fetches, reads, write-readback, halt at RUN cycle 7
        bus.instr_address = 32'hBFC0_0004; instr_probe = 1'b1; ins_q.push_back(32'h0);
        tick();
        bus.instr_address = 32'hBFC0_0000; ins_q.push_back(32'h8C02_0000);
        bus.data_read = 1'b1; bus.data_address = 32'hC; rd_q.push_back(32'h2222_2222);
        tick();
        instr_probe = 1'b0; bus.data_read = 1'b0;
        bus.data_write = 1'b1; bus.data_address = 32'h8; bus.data_writedata = 32'hDEAD_BEEF;
        tick();
        bus.data_write = 1'b0; bus.data_read = 1'b1; rd_q.push_back(32'hDEAD_BEEF);
        tick();
        bus.data_address = 32'h10; rd_q.push_back(32'h3333_3333);
        tick();
        bus.data_read = 1'b0;
        tick();
        bus.cpu_active = 1'b0;
        push_end(1'b0, 2'd0, 32'd7);
        wait_end(5);
        tick();
        check("done_frozen_count", bus.cycle_count, 32'd7);
        check("done_frozen_clk_en", 32'(bus.cpu_clk_enable), 32'd0);
        do_reset();

        // Run 2: RAM survives reset; asynchronous reset mid-run
        start_run();
        bus.data_read = 1'b1; bus.data_address = 32'h8; rd_q.push_back(32'hDEAD_BEEF);
        tick();
        bus.data_read = 1'b0; instr_probe = 1'b1; ins_q.push_back(32'h8C02_0000);
        tick();
        instr_probe = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrun");
        tick();
        rst_n = 1'b1;
        tick();

        // Run 3: out-of-window read
        start_run();
        bus.data_read = 1'b1; bus.data_address = 32'h400; rd_q.push_back(32'h0);
        push_end(1'b1, 2'd1, 32'd1);
        wait_end(5);
        do_reset();

        // Run 4: out-of-window write (would alias word 0 if not suppressed)
        start_run();
        bus.data_write = 1'b1; bus.data_address = 32'h400; bus.data_writedata = 32'hBAD0_0001;
        push_end(1'b1, 2'd1, 32'd1);
        wait_end(5);
        do_reset();

        // Run 5: unaligned write (would hit word 2 if not suppressed)
        start_run();
        bus.data_write = 1'b1; bus.data_address = 32'hA; bus.data_writedata = 32'hBAD0_0002;
        push_end(1'b1, 2'd1, 32'd1);
        wait_end(5);
        do_reset();

        // Run 6: read and write together
        start_run();
        bus.data_read = 1'b1; bus.data_address = 32'h0; rd_q.push_back(32'h0A0A_0A0A);
        tick();
        bus.data_write = 1'b1; bus.data_address = 32'h10; bus.data_writedata = 32'h5555_5555;
        push_end(1'b1, 2'd2, 32'd2);
        wait_end(5);
        do_reset();

        // Run 7: RAM unchanged by faulted writes, then timeout at 20 cycles
        start_run();
        bus.data_read = 1'b1; bus.data_address = 32'h10; rd_q.push_back(32'h3333_3333);
        bus.instr_address = 32'hBFC0_0008; instr_probe = 1'b1; ins_q.push_back(32'h0000_0008);
        tick();
        instr_probe = 1'b0; bus.instr_address = 32'hBFC0_0000;
        bus.data_address = 32'h8; rd_q.push_back(32'hDEAD_BEEF);
        tick();
        bus.data_address = 32'h0; rd_q.push_back(32'h0A0A_0A0A);
        tick();
        bus.data_address = 32'h3FC; rd_q.push_back(32'h7777_7777);
        tick();
        bus.data_read = 1'b0;
        push_end(1'b1, 2'd3, 32'd20);
        wait_end(40);
        tick();
        check("timeout_frozen_count", bus.cycle_count, 32'd20);

        if (rd_q.size() + ins_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL pending_reads: got %0d unchecked expected 0", rd_q.size() + ins_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
